// File: rtl/fifo_read_stream.sv
// Read-side consumer for the dual-clock FIFO: pops words through the FIFO read port,
// absorbs the one-cycle read latency in a 3-entry skid buffer and streams them out.
module fifo_read_stream #(
  parameter int DATA_LINES = 8,
  parameter int CNT_W      = 16
) (
  input  logic                  rclk,
  input  logic                  rrst,
  input  logic                  en,
  input  logic                  flush,
  input  logic                  rempty,
  input  logic [DATA_LINES-1:0] rdata,
  output logic                  rinc,
  output logic                  m_valid,
  input  logic                  m_ready,
  output logic [DATA_LINES-1:0] m_data,
  output logic                  flush_busy,
  output logic [CNT_W-1:0]      word_cnt
);

  typedef enum logic [1:0] {IDLE, STREAM, FLUSH} state_t;

  state_t                r_state;
  logic [1:0]            r_occ;
  logic                  r_inflight;
  logic [DATA_LINES-1:0] r_buf [3];
  logic [CNT_W-1:0]      r_cnt;

  logic       w_pop;
  logic       w_take;
  logic       w_cap;
  logic [2:0] w_credit;
  logic [1:0] w_wr_idx;

  // Credit counts the word already in flight so a full buffer never overflows.
  assign w_credit = {1'b0, r_occ} + {2'b00, r_inflight};
  assign rinc     = (r_state == FLUSH) ? ~rempty
                  : ((r_state == STREAM) & ~rempty & (w_credit < 3'd3));
  assign w_pop    = rinc & ~rempty;
  assign m_valid  = (r_occ != 2'd0);
  assign m_data   = r_buf[0];
  assign w_take   = m_valid & m_ready;
  assign w_cap    = r_inflight & (r_state != FLUSH) & ~flush;
  assign w_wr_idx = r_occ - {1'b0, w_take};

  assign flush_busy = (r_state == FLUSH);
  assign word_cnt   = r_cnt;

  always_ff @(posedge rclk or negedge rrst) begin
    if (!rrst) begin
      r_state    <= IDLE;
      r_occ      <= 2'd0;
      r_inflight <= 1'b0;
      r_cnt      <= '0;
      for (int i = 0; i < 3; i++) begin
        r_buf[i] <= '0;
      end
    end else begin
      r_inflight <= w_pop;

      if (w_take && (r_cnt != {CNT_W{1'b1}})) begin
        r_cnt <= r_cnt + 1'b1;
      end

      if (flush) begin
        r_occ <= 2'd0;
      end else if (r_state != FLUSH) begin
        r_occ <= r_occ + {1'b0, w_cap} - {1'b0, w_take};
        // Head entry is buffer slot 0; a pop shifts, the capture lands behind the survivors.
        if (w_take) begin
          r_buf[0] <= r_buf[1];
          r_buf[1] <= r_buf[2];
        end
        if (w_cap) begin
          r_buf[w_wr_idx] <= rdata;
        end
      end

      if (flush) begin
        r_state <= FLUSH;
      end else begin
        case (r_state)
          IDLE:    if (en) r_state <= STREAM;
          STREAM:  if (!en) r_state <= IDLE;
          FLUSH:   if (rempty && !r_inflight) r_state <= en ? STREAM : IDLE;
          default: r_state <= IDLE;
        endcase
      end
    end
  end

endmodule
